// File: rtl/jamma_input_mux.sv
// jamma_input_mux
//
// Scans the JAMMA joystick splitter and conditions the board inputs for the
// arcade core. The splitter select line alternates between player 1 and
// player 2. After a settle period the shared jjoy bus is captured for the
// selected player. Each captured word is debounced per bit. The DB9 joystick
// is merged into player 1 at capture time. The coin switches are
// synchronised, falling-edge detected and stretched to a minimum low time.
// The service switch is synchronised.
// All joystick, coin and service signals are active-low.
//
// Optional build macro:
//   JAMMA_SOCD_EN - when defined, a debounced word that reports both up and
//                   down (or both left and right) pressed reports neither.
//                   Fire and start bits are unaffected.
//
// Parameters:
//   SETTLE_CYCLES     - pclk cycles jselect is held before each sample (>= 1)
//   DEBOUNCE_SAMPLES  - identical consecutive samples needed per bit (2..8)
//   COIN_PULSE_CYCLES - minimum low time of each coin output (>= 1)
//
// Ports:
//   pclk          in   system clock
//   reset         in   synchronous, active-high reset
//   jjoy[7:0]     in   shared JAMMA bus: up,down,left,right,fire1-3,start
//   local_joy[5:0] in  DB9 joystick, same order as jjoy[5:0]
//   jcoin[1:0]    in   coin switches (asynchronous)
//   jservice      in   service switch (asynchronous)
//   jselect       out  splitter select: 0 = player 1, 1 = player 2
//   joystick1     out  debounced player 1 word
//   joystick2     out  debounced player 2 word
//   coin[1:0]     out  conditioned coin outputs
//   service       out  synchronised service switch
//   sample_strobe out  one-cycle pulse on each player 2 sample (end of scan)

module jamma_input_mux #(
    parameter int unsigned SETTLE_CYCLES     = 16,
    parameter int unsigned DEBOUNCE_SAMPLES  = 3,
    parameter int unsigned COIN_PULSE_CYCLES = 1024
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic [7:0] jjoy,
    input  logic [5:0] local_joy,
    input  logic [1:0] jcoin,
    input  logic       jservice,
    output logic       jselect,
    output logic [7:0] joystick1,
    output logic [7:0] joystick2,
    output logic [1:0] coin,
    output logic       service,
    output logic       sample_strobe
);

    localparam int unsigned SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned CCW = $clog2(COIN_PULSE_CYCLES + 1);
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);
    localparam logic [CCW-1:0] COIN_LOAD   = CCW'(COIN_PULSE_CYCLES);

    typedef enum logic [1:0] {
        P1_SETTLE,
        P1_SAMPLE,
        P2_SETTLE,
        P2_SAMPLE
    } scan_state_t;

    typedef logic [DEBOUNCE_SAMPLES-1:0][7:0] history_t;

    // ------------------------------------------------------------------
    // Scan sequencer
    // ------------------------------------------------------------------
    scan_state_t    state;
    scan_state_t    state_next;
    logic [SCW-1:0] settle_cnt;
    logic [SCW-1:0] settle_cnt_next;
    logic           jselect_next;
    logic           strobe_next;
    logic           p1_take;
    logic           p2_take;

    always_comb begin
        state_next      = state;
        settle_cnt_next = settle_cnt;
        p1_take         = 1'b0;
        p2_take         = 1'b0;
        case (state)
            P1_SETTLE: begin
                if (settle_cnt == '0) state_next = P1_SAMPLE;
                else                  settle_cnt_next = settle_cnt - SCW'(1);
            end
            P1_SAMPLE: begin
                p1_take         = 1'b1;
                settle_cnt_next = SETTLE_LOAD;
                state_next      = P2_SETTLE;
            end
            P2_SETTLE: begin
                if (settle_cnt == '0) state_next = P2_SAMPLE;
                else                  settle_cnt_next = settle_cnt - SCW'(1);
            end
            P2_SAMPLE: begin
                p2_take         = 1'b1;
                settle_cnt_next = SETTLE_LOAD;
                state_next      = P1_SETTLE;
            end
            default: begin
                state_next      = P1_SETTLE;
                settle_cnt_next = SETTLE_LOAD;
            end
        endcase
        // jselect and the strobe are registered from the next state so they
        // line up exactly with the state they describe.
        jselect_next = (state_next == P2_SETTLE) || (state_next == P2_SAMPLE);
        strobe_next  = (state_next == P2_SAMPLE);
    end

    // ------------------------------------------------------------------
    // Capture and debounce
    // ------------------------------------------------------------------
    logic [7:0] p1_raw;
    history_t   hist1;
    history_t   hist2;
    history_t   hist1_next;
    history_t   hist2_next;
    logic [7:0] deb1;
    logic [7:0] deb2;
    logic [7:0] deb1_next;
    logic [7:0] deb2_next;

    assign p1_raw = jjoy & {2'b11, local_joy};

    // A bit goes high when every history entry is high, low when every entry
    // is low, and otherwise keeps its current level.
    function automatic logic [7:0] debounce(input history_t hist, input logic [7:0] held);
        logic [7:0] all_ones;
        logic [7:0] any_one;
        all_ones = '1;
        any_one  = '0;
        for (int unsigned i = 0; i < DEBOUNCE_SAMPLES; i++) begin
            all_ones = all_ones & hist[i];
            any_one  = any_one | hist[i];
        end
        return all_ones | (held & any_one);
    endfunction

    function automatic logic [7:0] socd(input logic [7:0] word);
        logic [7:0] result;
        result = word;
`ifdef JAMMA_SOCD_EN
        if (word[1:0] == 2'b00) result[1:0] = 2'b11;
        if (word[3:2] == 2'b00) result[3:2] = 2'b11;
`endif
        return result;
    endfunction

    always_comb begin
        hist1_next = hist1;
        hist2_next = hist2;
        if (p1_take) hist1_next = {hist1[DEBOUNCE_SAMPLES-2:0], p1_raw};
        if (p2_take) hist2_next = {hist2[DEBOUNCE_SAMPLES-2:0], jjoy};
        // Decoding the shifted history lets the output move on the edge that
        // captures the deciding sample.
        deb1_next = debounce(hist1_next, deb1);
        deb2_next = debounce(hist2_next, deb2);
    end

    // ------------------------------------------------------------------
    // Coin conditioning
    // ------------------------------------------------------------------
    logic [1:0]     coin_s1;
    logic [1:0]     coin_s2;
    logic [1:0]     coin_s3;
    logic [1:0]     coin_fall;
    logic [1:0]     coin_next;
    logic [CCW-1:0] coin_cnt      [2];
    logic [CCW-1:0] coin_cnt_next [2];

    always_comb begin
        coin_fall = coin_s3 & ~coin_s2;
        coin_next = 2'b11;
        for (int unsigned i = 0; i < 2; i++) begin
            coin_cnt_next[i] = coin_cnt[i];
            if (coin_fall[i])               coin_cnt_next[i] = COIN_LOAD;
            else if (coin_cnt[i] != '0)     coin_cnt_next[i] = coin_cnt[i] - CCW'(1);
            // Held low by the stretch or by a press that outlasts it.
            coin_next[i] = coin_s2[i] & (coin_cnt_next[i] == '0);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic svc_s1;

    always_ff @(posedge pclk) begin
        if (reset) begin
            state         <= P1_SETTLE;
            settle_cnt    <= SETTLE_LOAD;
            jselect       <= 1'b0;
            sample_strobe <= 1'b0;
            hist1         <= '1;
            hist2         <= '1;
            deb1          <= '1;
            deb2          <= '1;
            joystick1     <= '1;
            joystick2     <= '1;
            coin_s1       <= '1;
            coin_s2       <= '1;
            coin_s3       <= '1;
            for (int unsigned i = 0; i < 2; i++) coin_cnt[i] <= '0;
            coin          <= 2'b11;
            svc_s1        <= 1'b1;
            service       <= 1'b1;
        end else begin
            state         <= state_next;
            settle_cnt    <= settle_cnt_next;
            jselect       <= jselect_next;
            sample_strobe <= strobe_next;
            hist1         <= hist1_next;
            hist2         <= hist2_next;
            deb1          <= deb1_next;
            deb2          <= deb2_next;
            joystick1     <= socd(deb1_next);
            joystick2     <= socd(deb2_next);
            coin_s1       <= jcoin;
            coin_s2       <= coin_s1;
            coin_s3       <= coin_s2;
            for (int unsigned i = 0; i < 2; i++) coin_cnt[i] <= coin_cnt_next[i];
            coin          <= coin_next;
            svc_s1        <= jservice;
            service       <= svc_s1;
        end
    end

endmodule
